// File: rtl/iiitb_wm_pkg.sv
// Shared encodings for the programmable washing-machine controller.
package iiitb_wm_pkg;

  // State encoding is visible on state_o, so the values are fixed.
  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StFill       = 3'd1,
    StDetergent  = 3'd2,
    StWash       = 3'd3,
    StDrain      = 3'd4,
    StSpin       = 3'd5,
    StDone       = 3'd6,
    StAbortDrain = 3'd7
  } state_e;

  // SOAP is the first wash; RINSE covers every later fill/wash/drain pass.
  typedef enum logic {
    PhSoap  = 1'b0,
    PhRinse = 1'b1
  } phase_e;

  // States in which pause freezes the machine.
  function automatic logic is_pausable(state_e s);
    return (s == StFill) || (s == StDetergent) || (s == StWash) ||
           (s == StDrain) || (s == StSpin);
  endfunction

  // States from which abort forces an emergency drain.
  function automatic logic is_abortable(state_e s);
    return (s != StIdle) && (s != StDone);
  endfunction

endpackage

// File: rtl/iiitb_wm_timer.sv
// Loadable down-counter shared by the WASH and SPIN phases.
// Saturates at zero; expire flags the decrement out of count==1.
module iiitb_wm_timer #(
  parameter int unsigned TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               expire
);

  logic [TIMER_W-1:0] count_q, count_d;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = en && !load && (count_q == TIMER_W'(1));

endmodule

// File: rtl/iiitb_wm_prog.sv
// Programmable washing-machine controller: soap wash, N rinse passes, spin,
// with pause and abort. Actuators decode from registered state and phase;
// pause gates the valve/motor drives in the same cycle it freezes the timer.
module iiitb_wm_prog
  import iiitb_wm_pkg::*;
#(
  parameter int unsigned TIMER_W = 16,
  parameter int unsigned RINSE_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               door_close,
  input  logic               filled,
  input  logic               detergent_added,
  input  logic               drained,
  input  logic               pause,
  input  logic               abort,
  input  logic [TIMER_W-1:0] wash_time,
  input  logic [TIMER_W-1:0] spin_time,
  input  logic [RINSE_W-1:0] n_rinse,
  output logic               door_lock,
  output logic               motor_on,
  output logic               fill_valve_on,
  output logic               drain_valve_on,
  output logic               done,
  output logic               soap_wash,
  output logic               water_wash,
  output logic [RINSE_W-1:0] rinse_count,
  output logic [2:0]         state_o
);

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [RINSE_W-1:0] rinse_q, rinse_d;
  logic [TIMER_W-1:0] wash_q, wash_d;
  logic [TIMER_W-1:0] spin_q, spin_d;
  logic [RINSE_W-1:0] nr_q, nr_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_en;
  logic               tmr_expire;
  logic [TIMER_W-1:0] wash_len;
  logic [TIMER_W-1:0] spin_len;
  logic               paused;

  // A zero program time still runs the motor for one cycle.
  assign wash_len = (wash_q == '0) ? TIMER_W'(1) : wash_q;
  assign spin_len = (spin_q == '0) ? TIMER_W'(1) : spin_q;

  assign paused = pause && is_pausable(state_q);

  // Timer only counts in the motor phases, and not while frozen or aborting.
  assign tmr_en = ((state_q == StWash) || (state_q == StSpin)) && !pause && !abort;

  iiitb_wm_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expire   (tmr_expire)
  );

  // Next-state: abort beats pause beats the normal program flow.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    rinse_d  = rinse_q;
    wash_d   = wash_q;
    spin_d   = spin_q;
    nr_d     = nr_q;
    tmr_load = 1'b0;
    tmr_val  = wash_len;

    if (abort && is_abortable(state_q)) begin
      state_d = StAbortDrain;
    end else if (paused) begin
      state_d = state_q;
    end else begin
      case (state_q)
        StIdle: begin
          // door_close matters only here; once locked it is ignored.
          if (start && door_close) begin
            state_d = StFill;
            phase_d = PhSoap;
            rinse_d = '0;
            wash_d  = wash_time;
            spin_d  = spin_time;
            nr_d    = n_rinse;
          end
        end
        StFill: begin
          if (filled) begin
            if (phase_q == PhSoap) begin
              state_d = StDetergent;
            end else begin
              state_d  = StWash;
              tmr_load = 1'b1;
              tmr_val  = wash_len;
            end
          end
        end
        StDetergent: begin
          if (detergent_added) begin
            state_d  = StWash;
            tmr_load = 1'b1;
            tmr_val  = wash_len;
          end
        end
        StWash: begin
          if (tmr_expire) begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (drained) begin
            if (rinse_q < nr_q) begin
              rinse_d = rinse_q + RINSE_W'(1);
              phase_d = PhRinse;
              state_d = StFill;
            end else begin
              state_d  = StSpin;
              tmr_load = 1'b1;
              tmr_val  = spin_len;
            end
          end
        end
        StSpin: begin
          if (tmr_expire) begin
            state_d = StDone;
          end
        end
        StDone: begin
          if (!start) begin
            state_d = StIdle;
            rinse_d = '0;
          end
        end
        StAbortDrain: begin
          // Clearing here keeps rinse_count at zero whenever IDLE is shown.
          if (drained) begin
            state_d = StIdle;
            rinse_d = '0;
          end
        end
        default: begin
          state_d = StIdle;
          rinse_d = '0;
        end
      endcase
    end
  end

  // Program state and latched program registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      phase_q <= PhSoap;
      rinse_q <= '0;
      wash_q  <= '0;
      spin_q  <= '0;
      nr_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rinse_q <= rinse_d;
      wash_q  <= wash_d;
      spin_q  <= spin_d;
      nr_q    <= nr_d;
    end
  end

  // Output decode from registered state/phase; pause drops only the actuators.
  always_comb begin
    door_lock      = 1'b0;
    motor_on       = 1'b0;
    fill_valve_on  = 1'b0;
    drain_valve_on = 1'b0;
    done           = 1'b0;
    soap_wash      = 1'b0;
    water_wash     = 1'b0;
    case (state_q)
      StFill: begin
        door_lock     = 1'b1;
        fill_valve_on = !paused;
        water_wash    = (phase_q == PhRinse);
      end
      StDetergent: begin
        door_lock = 1'b1;
        soap_wash = 1'b1;
      end
      StWash: begin
        door_lock  = 1'b1;
        motor_on   = !paused;
        soap_wash  = (phase_q == PhSoap);
        water_wash = (phase_q == PhRinse);
      end
      StDrain: begin
        door_lock      = 1'b1;
        drain_valve_on = !paused;
        soap_wash      = (phase_q == PhSoap);
        water_wash     = (phase_q == PhRinse);
      end
      StSpin: begin
        door_lock      = 1'b1;
        motor_on       = !paused;
        drain_valve_on = !paused;
      end
      StDone: begin
        done = 1'b1;
      end
      StAbortDrain: begin
        door_lock      = 1'b1;
        drain_valve_on = 1'b1;
      end
      default: begin
        door_lock = 1'b0;
      end
    endcase
  end

  assign rinse_count = rinse_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_iiitb_wm_prog.sv
// Bench for iiitb_wm_prog: a cycle model of the program rules checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_iiitb_wm_prog;

  localparam int TW = 16;
  localparam int RW = 2;

  localparam int S_IDLE = 0, S_FILL = 1, S_DET = 2, S_WASH = 3;
  localparam int S_DRAIN = 4, S_SPIN = 5, S_DONE = 6, S_ABORT = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          door_close = 1'b0;
  logic          filled = 1'b0;
  logic          detergent_added = 1'b0;
  logic          drained = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [TW-1:0] wash_time = '0;
  logic [TW-1:0] spin_time = '0;
  logic [RW-1:0] n_rinse = '0;

  logic          door_lock, motor_on, fill_valve_on, drain_valve_on;
  logic          done, soap_wash, water_wash;
  logic [RW-1:0] rinse_count;
  logic [2:0]    state_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  iiitb_wm_prog #(
    .TIMER_W (TW),
    .RINSE_W (RW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .door_close      (door_close),
    .filled          (filled),
    .detergent_added (detergent_added),
    .drained         (drained),
    .pause           (pause),
    .abort           (abort),
    .wash_time       (wash_time),
    .spin_time       (spin_time),
    .n_rinse         (n_rinse),
    .door_lock       (door_lock),
    .motor_on        (motor_on),
    .fill_valve_on   (fill_valve_on),
    .drain_valve_on  (drain_valve_on),
    .done            (done),
    .soap_wash       (soap_wash),
    .water_wash      (water_wash),
    .rinse_count     (rinse_count),
    .state_o         (state_o)
  );

  // ---------------- model: program position + unpaused cycles left ----------
  int m_st    = S_IDLE;
  bit m_rinse = 1'b0;
  int m_rc    = 0;
  int m_left  = 0;
  int m_wash  = 0;
  int m_spin  = 0;
  int m_nr    = 0;

  function automatic int at_least_one(int v);
    return (v == 0) ? 1 : v;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!reset) begin
      m_st = S_IDLE; m_rinse = 1'b0; m_rc = 0; m_left = 0;
      m_wash = 0; m_spin = 0; m_nr = 0;
    end else if (abort && m_st != S_IDLE && m_st != S_DONE) begin
      m_st = S_ABORT;
    end else if (pause && m_st >= S_FILL && m_st <= S_SPIN) begin
      m_st = m_st;
    end else begin
      case (m_st)
        S_IDLE: if (start && door_close) begin
          m_st = S_FILL; m_rinse = 1'b0; m_rc = 0;
          m_wash = int'(wash_time); m_spin = int'(spin_time); m_nr = int'(n_rinse);
        end
        S_FILL: if (filled) begin
          if (!m_rinse) m_st = S_DET;
          else begin m_st = S_WASH; m_left = at_least_one(m_wash); end
        end
        S_DET: if (detergent_added) begin
          m_st = S_WASH; m_left = at_least_one(m_wash);
        end
        S_WASH: begin
          m_left = m_left - 1;
          if (m_left == 0) m_st = S_DRAIN;
        end
        S_DRAIN: if (drained) begin
          if (m_rc < m_nr) begin m_rc = m_rc + 1; m_rinse = 1'b1; m_st = S_FILL; end
          else begin m_st = S_SPIN; m_left = at_least_one(m_spin); end
        end
        S_SPIN: begin
          m_left = m_left - 1;
          if (m_left == 0) m_st = S_DONE;
        end
        S_DONE:  if (!start) begin m_st = S_IDLE; m_rc = 0; end
        default: if (drained) begin m_st = S_IDLE; m_rc = 0; end
      endcase
    end
  end

  // Expected output vector {lock,motor,fill,drain,done,soap,water,rc,state}.
  function automatic logic [11:0] model_outs(int st, bit rph, int rc, bit pz_in);
    bit pz;
    logic [1:0] rcv;
    logic [2:0] stv;
    pz  = pz_in && st >= S_FILL && st <= S_SPIN;
    rcv = rc[1:0];
    stv = st[2:0];
    return {(st != S_IDLE && st != S_DONE),
            ((st == S_WASH || st == S_SPIN) && !pz),
            (st == S_FILL && !pz),
            (((st == S_DRAIN || st == S_SPIN) && !pz) || st == S_ABORT),
            (st == S_DONE),
            ((st == S_DET || st == S_WASH || st == S_DRAIN) && !rph),
            ((st == S_FILL || st == S_WASH || st == S_DRAIN) && rph),
            rcv, stv};
  endfunction

  function automatic logic [11:0] dut_outs();
    return {door_lock, motor_on, fill_valve_on, drain_valve_on, done,
            soap_wash, water_wash, rinse_count, state_o};
  endfunction

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      logic [11:0] e, a;
      e = model_outs(m_st, m_rinse, m_rc, pause);
      a = dut_outs();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got %b expected %b", $time, a, e);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // 0 = filled, 1 = detergent_added, 2 = drained; one-cycle pulse.
  task automatic pulse(int which, int exp_state, string name);
    case (which)
      0: filled = 1'b1;
      1: detergent_added = 1'b1;
      default: drained = 1'b1;
    endcase
    tick();
    filled = 1'b0; detergent_added = 1'b0; drained = 1'b0;
    chk(name, int'(state_o), exp_state);
  endtask

  // Counts cycles spent in state s and how many had the motor on.
  task automatic count_in(int s, output int cyc, output int mot);
    cyc = 0; mot = 0;
    while (int'(state_o) == s && cyc < 100) begin
      cyc++;
      if (motor_on) mot++;
      tick();
    end
  endtask

  task automatic begin_prog(int w, int sp, int nr);
    wash_time = TW'(w); spin_time = TW'(sp); n_rinse = RW'(nr);
    door_close = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_to_fill", int'(state_o), S_FILL);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, mot, i;

    // Reset
    reset = 1'b0;
    tick(); tick();
    cmp_en = 1'b1;
    chk("reset_state", int'(state_o), S_IDLE);
    chk("reset_outputs", int'(dut_outs()), 0);
    reset = 1'b1;
    tick();

    // Single soap wash, no rinses: 5 wash cycles, 3 spin cycles
    begin_prog(5, 3, 0);
    tick();
    pulse(0, S_DET, "t1_detergent");
    pulse(1, S_WASH, "t1_wash");
    count_in(S_WASH, cyc, mot);
    chk("t1_wash_motor", mot, 5);
    chk("t1_drain", int'(state_o), S_DRAIN);
    pulse(2, S_SPIN, "t1_spin");
    count_in(S_SPIN, cyc, mot);
    chk("t1_spin_motor", mot, 3);
    chk("t1_done", int'(done), 1);
    chk("t1_rinse_count", int'(rinse_count), 0);
    tick();
    chk("t1_idle", int'(state_o), S_IDLE);

    // Two rinse passes
    begin_prog(2, 2, 2);
    pulse(0, S_DET, "t2_detergent");
    pulse(1, S_WASH, "t2_wash");
    count_in(S_WASH, cyc, mot);
    chk("t2_soap_drain_soap", int'(soap_wash), 1);
    chk("t2_soap_drain_water", int'(water_wash), 0);
    for (int r = 1; r <= 2; r++) begin
      pulse(2, S_FILL, "t2_refill");
      chk("t2_water_wash", int'(water_wash), 1);
      chk("t2_rinse_count", int'(rinse_count), r);
      pulse(0, S_WASH, "t2_rinse_wash");
      count_in(S_WASH, cyc, mot);
      chk("t2_rinse_motor", mot, 2);
    end
    pulse(2, S_SPIN, "t2_spin");
    count_in(S_SPIN, cyc, mot);
    chk("t2_done", int'(state_o), S_DONE);
    chk("t2_final_rinse_count", int'(rinse_count), 2);
    tick();
    chk("t2_idle_rinse_count", int'(rinse_count), 0);

    // start without door_close, then pause in WASH, then DONE hold
    wash_time = TW'(6); spin_time = TW'(1); n_rinse = '0;
    door_close = 1'b0; start = 1'b1;
    repeat (10) tick();
    chk("t3_stay_idle", int'(state_o), S_IDLE);
    chk("t3_unlocked", int'(door_lock), 0);
    door_close = 1'b1;
    tick();
    chk("t3_fill", int'(state_o), S_FILL);
    pulse(0, S_DET, "t3_detergent");
    pulse(1, S_WASH, "t3_wash");
    // 6 unpaused cycles + 4 paused (cycles 3..6) = 10 cycles in WASH
    i = 1;
    while (int'(state_o) == S_WASH && i <= 30) begin
      pause = (i >= 3 && i <= 6);
      if (i == 2) door_close = 1'b0;
      #1;
      chk("t4_motor_vs_pause", int'(motor_on), pause ? 0 : 1);
      tick();
      i++;
    end
    pause = 1'b0;
    chk("t4_wash_cycles", i - 1, 10);
    chk("t4_drain", int'(state_o), S_DRAIN);
    pulse(2, S_SPIN, "t4_spin");
    count_in(S_SPIN, cyc, mot);
    chk("t4_spin_motor", mot, 1);
    repeat (3) tick();
    chk("t4_done_held", int'(done), 1);
    start = 1'b0;
    tick();
    chk("t4_idle", int'(state_o), S_IDLE);

    // abort with pause in WASH
    begin_prog(4, 2, 0);
    pulse(0, S_DET, "t5_detergent");
    pulse(1, S_WASH, "t5_wash");
    tick();
    abort = 1'b1; pause = 1'b1;
    tick();
    chk("t5_abort_state", int'(state_o), S_ABORT);
    chk("t5_abort_drain", int'(drain_valve_on), 1);
    chk("t5_abort_lock", int'(door_lock), 1);
    abort = 1'b0;
    pulse(2, S_IDLE, "t5_abort_idle");
    pause = 1'b0;
    chk("t5_no_done", int'(done), 0);

    // reset mid-SPIN, then zero wash/spin times
    begin_prog(3, 5, 1);
    pulse(0, S_DET, "t6_detergent");
    pulse(1, S_WASH, "t6_wash");
    count_in(S_WASH, cyc, mot);
    pulse(2, S_FILL, "t6_rinse_fill");
    pulse(0, S_WASH, "t6_rinse_wash");
    count_in(S_WASH, cyc, mot);
    pulse(2, S_SPIN, "t6_spin");
    tick(); tick();
    chk("t6_mid_spin", int'(state_o), S_SPIN);
    reset = 1'b0;
    tick();
    chk("t6_reset_state", int'(state_o), S_IDLE);
    chk("t6_reset_outputs", int'(dut_outs()), 0);
    reset = 1'b1;
    begin_prog(0, 0, 0);
    pulse(0, S_DET, "t6b_detergent");
    pulse(1, S_WASH, "t6b_wash");
    count_in(S_WASH, cyc, mot);
    chk("t6b_wash_cycles", cyc, 1);
    pulse(2, S_SPIN, "t6b_spin");
    count_in(S_SPIN, cyc, mot);
    chk("t6b_spin_cycles", cyc, 1);
    chk("t6b_done", int'(state_o), S_DONE);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
